// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches over req/gnt/rvalid,
// buffers responses in a small FIFO and drives the IF/ID register toward decode.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module if_stage #(
  parameter logic [`INST_ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                          FETCH_DEPTH = 2,
  parameter logic [`INST_WIDTH-1:0]      NOP_INST    = 32'h0000_0013
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req_o,
  output logic [`INST_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                        imem_gnt_i,
  input  logic                        imem_rvalid_i,
  input  logic [`INST_WIDTH-1:0]      imem_rdata_i,
  input  logic                        stall_i,
  input  logic                        redirect_i,
  input  logic [`INST_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic [`INST_WIDTH-1:0]      inst_o,
  output logic [`INST_ADDR_WIDTH-1:0] inst_addr_o,
  output logic                        inst_valid_o
);
  localparam int IW = `INST_WIDTH;
  localparam int AW = `INST_ADDR_WIDTH;
  localparam int CW = $clog2(FETCH_DEPTH + 1);
  localparam int PW = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FETCH_DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(FETCH_DEPTH - 1);

  logic [AW-1:0] r_pc;
  logic [CW-1:0] r_out, r_drop, r_cnt;
  logic [PW-1:0] r_wp, r_rp, r_aw, r_ar;
  logic [IW-1:0] r_fd [FETCH_DEPTH];
  logic [AW-1:0] r_fa [FETCH_DEPTH];
  logic [AW-1:0] r_pa [FETCH_DEPTH];
  logic [IW-1:0] r_inst;
  logic [AW-1:0] r_inst_addr;
  logic          r_valid;

  logic          w_req, w_gnt, w_rsp, w_drop_rsp, w_live, w_empty;
  logic          w_bypass, w_push, w_pop;
  logic [CW-1:0] w_out_nxt;
  logic [AW-1:0] w_rsp_addr, w_redir_pc;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit: in-flight fetches plus buffered responses never exceed the FIFO depth.
  assign w_req      = !rst && !redirect_i && (({1'b0, r_out} + {1'b0, r_cnt}) < DEPTH_W);
  assign w_gnt      = w_req && imem_gnt_i;
  assign w_rsp      = imem_rvalid_i && (r_out != '0);
  assign w_drop_rsp = w_rsp && (r_drop != '0);
  assign w_live     = w_rsp && !w_drop_rsp;
  assign w_empty    = (r_cnt == '0);
  assign w_bypass   = w_live && w_empty && !stall_i;
  assign w_push     = w_live && !w_bypass && !redirect_i;
  assign w_pop      = !stall_i && !redirect_i && !w_empty;
  assign w_out_nxt  = r_out + CW'(w_gnt) - CW'(w_rsp);
  assign w_rsp_addr = r_pa[r_ar];
  assign w_redir_pc = redirect_addr_i & ~AW'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_out       <= '0;
      r_drop      <= '0;
      r_cnt       <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_aw        <= '0;
      r_ar        <= '0;
      r_inst      <= NOP_INST;
      r_inst_addr <= '0;
      r_valid     <= 1'b0;
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        r_fd[i] <= '0;
        r_fa[i] <= '0;
        r_pa[i] <= '0;
      end
    end else begin
      r_out <= w_out_nxt;
      // Granted addresses travel with their responses, dropped or not.
      if (w_gnt) begin
        r_pa[r_aw] <= r_pc;
        r_aw       <= inc(r_aw);
      end
      if (w_rsp) r_ar <= inc(r_ar);

      if (redirect_i) begin
        r_pc    <= w_redir_pc;
        r_drop  <= w_out_nxt;
        r_cnt   <= '0;
        r_wp    <= '0;
        r_rp    <= '0;
        r_inst  <= NOP_INST;
        r_valid <= 1'b0;
      end else begin
        if (w_gnt) r_pc <= r_pc + AW'(4);
        r_drop <= r_drop - CW'(w_drop_rsp);
        r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
        if (w_push) begin
          r_fd[r_wp] <= imem_rdata_i;
          r_fa[r_wp] <= w_rsp_addr;
          r_wp       <= inc(r_wp);
        end
        if (w_pop) r_rp <= inc(r_rp);
        if (!stall_i) begin
          if (w_pop) begin
            r_inst      <= r_fd[r_rp];
            r_inst_addr <= r_fa[r_rp];
            r_valid     <= 1'b1;
          end else if (w_bypass) begin
            r_inst      <= imem_rdata_i;
            r_inst_addr <= w_rsp_addr;
            r_valid     <= 1'b1;
          end else begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign imem_req_o   = w_req;
  assign imem_addr_o  = r_pc;
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_inst_addr;
  assign inst_valid_o = r_valid;

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (r_out != '0));
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: grant-limited memory model, expected fetch addresses queued by the
// stimulus and popped by a monitor each time the IF/ID register loads a valid instruction.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_addr_i;
  logic [31:0] inst_o, inst_addr_o;
  logic        inst_valid_o;

  int          n_cmp = 0, n_bad = 0;
  int          grants_done = 0, grant_limit = 0;
  logic        rsp_en, mon_en, ld_q = 1'b0;
  logic [31:0] gq [$];
  logic [31:0] exp_q [$];

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  // Memory grants only while the stimulus has granted budget left.
  assign imem_gnt_i = (grants_done < grant_limit);

  always @(posedge clk) begin
    ld_q <= !stall_i && !redirect_i && !rst;
    if (!rst && imem_req_o && imem_gnt_i) begin
      gq.push_back(imem_addr_o);
      grants_done <= grants_done + 1;
    end
  end

  // Responses in grant order, data equals address, one cycle after grant at the earliest.
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      gq.delete();
      imem_rvalid_i = 1'b0;
    end else if (rsp_en && gq.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = gq.pop_front();
    end else begin
      imem_rvalid_i = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (mon_en && !rst && ld_q && inst_valid_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_inst: got addr %h, required no valid output", inst_addr_o);
      end else begin
        e = exp_q.pop_front();
        if (inst_addr_o !== e || inst_o !== e) begin
          n_bad++;
          $display("FAIL stream: got addr %h inst %h, required addr %h inst %h",
                   inst_addr_o, inst_o, e, e);
        end
      end
    end
  end

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || gq.size() != 0 || imem_rvalid_i || grants_done != grant_limit)
           && k < 80) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 80) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d expected items left, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0;
    rsp_en = 1'b1; mon_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_inst", inst_o, NOP);
    chk("rst_addr", inst_addr_o, 32'h0);
    chk("rst_valid", 32'(inst_valid_o), 32'h0);
    chk("rst_req", 32'(imem_req_o), 32'h0);

    // 1: back-to-back stream from RESET_PC
    rst = 1'b0;
    grant_limit = grants_done + 8;
    push_seq(32'h0, 8);
    @(negedge clk);
    chk("t1_not_yet_valid", 32'(inst_valid_o), 32'h0);
    @(negedge clk);
    chk("t1_first_valid", 32'(inst_valid_o), 32'h1);
    chk("t1_first_addr", inst_addr_o, 32'h0);
    wait_drain();

    // 4: request held without grant, address stable
    repeat (5) begin
      @(negedge clk);
      chk("t4_req_held", 32'(imem_req_o), 32'h1);
      chk("t4_addr_stable", imem_addr_o, 32'h20);
    end

    // 2: stall for three cycles mid-stream
    grant_limit += 8;
    push_seq(32'h20, 8);
    repeat (3) @(negedge clk);
    stall_i = 1'b1;
    @(negedge clk);
    chk("t2_hold_addr1", inst_addr_o, 32'h24);
    @(negedge clk);
    chk("t2_hold_addr2", inst_addr_o, 32'h24);
    chk("t2_credit_stop", 32'(imem_req_o), 32'h0);
    @(negedge clk);
    chk("t2_hold_addr3", inst_addr_o, 32'h24);
    chk("t2_hold_inst", inst_o, 32'h24);
    chk("t2_hold_valid", 32'(inst_valid_o), 32'h1);
    stall_i = 1'b0;
    wait_drain();

    // 3: redirect with two fetches outstanding
    redirect_i = 1'b1; redirect_addr_i = 32'h10; rsp_en = 1'b0;
    #1 chk("t3_no_req_on_redirect", 32'(imem_req_o), 32'h0);
    @(negedge clk);
    redirect_i = 1'b0;
    grant_limit += 2;
    repeat (2) @(negedge clk);
    chk("t3_two_outstanding", 32'(imem_req_o), 32'h0);
    chk("t3_pc_after_grants", imem_addr_o, 32'h18);
    redirect_i = 1'b1; redirect_addr_i = 32'h103;
    @(negedge clk);
    chk("t3_flush_valid", 32'(inst_valid_o), 32'h0);
    redirect_i = 1'b0; rsp_en = 1'b1;
    grant_limit += 3;
    push_seq(32'h100, 3);
    wait_drain();

    // 5: redirect and stall together while a fetch is in flight and gnt is high
    rsp_en = 1'b1;
    grant_limit += 1;
    push_seq(32'h10C, 1);
    @(negedge clk);
    grant_limit += 1; rsp_en = 1'b0;
    @(negedge clk);
    chk("t5_pre_valid", 32'(inst_valid_o), 32'h1);
    stall_i = 1'b1; redirect_i = 1'b1; redirect_addr_i = 32'h200;
    grant_limit += 1;
    @(negedge clk);
    chk("t5_flush_valid", 32'(inst_valid_o), 32'h0);
    chk("t5_flush_inst", inst_o, NOP);
    redirect_i = 1'b0; stall_i = 1'b0; rsp_en = 1'b1;
    #1 chk("t5_restart_req", 32'(imem_req_o), 32'h1);
    chk("t5_restart_addr", imem_addr_o, 32'h200);
    grant_limit += 1;
    push_seq(32'h200, 2);
    wait_drain();

    // 6: asynchronous reset mid-stream
    mon_en = 1'b0;
    grant_limit = grants_done + 100;
    repeat (4) @(negedge clk);
    chk("t6_pre_valid", 32'(inst_valid_o), 32'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_async_inst", inst_o, NOP);
    chk("t6_async_addr", inst_addr_o, 32'h0);
    chk("t6_async_valid", 32'(inst_valid_o), 32'h0);
    chk("t6_async_req", 32'(imem_req_o), 32'h0);
    @(negedge clk);
    grant_limit = grants_done;
    @(negedge clk);
    rst = 1'b0; mon_en = 1'b1;
    #1 chk("t6_restart_addr", imem_addr_o, 32'h0);
    grant_limit = grants_done + 3;
    push_seq(32'h0, 3);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
